rs_decode_sequencer: RTL and testbench

Frame-level controller for the RS(15,11) GF(16) decoder datapath. Accepts the 4-bit received-symbol stream one frame of 15 symbols at a time and drives the syndrome stage's clear and enable strobes. Starts and supervises the key-equation (Berlekamp-Massey) solver, then paces the Chien/Forney correction and output stage under a downstream ready handshake. Sits between the symbol source and `decoder_top`'s internal stages and owns all per-frame sequencing.

---
 rtl/rs_decode_sequencer.sv | 142 ++++++++++++++
 tb/tb_rs_decode_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_decode_sequencer.sv
// Purpose : per-frame sequencer for the RS(15,11) decoder; receive -> syndrome -> key equation -> correct/output.
// Latency : last input transfer -> one SYND cycle -> first output (clean); solver frames add the bm_done wait.
// Backpres: in_ready only in RECV; out_ready=0 freezes corr_index and all CORRECT-phase outputs.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   in_valid / in_ready   input symbol handshake; synd_en/synd_clear strobe the syndrome stage
//   sym_index             index of the next symbol to be accepted
//   synd_zero             all syndromes zero (looked at in SYND only)
//   bm_start / bm_done    key-equation solver start pulse / completion
//   corr_en, bypass       correction stage active / pass symbols through uncorrected
//   corr_index            index of the symbol presented on the output
//   out_valid / out_ready output handshake, out_last marks symbol N-1
//   frame_err             one-cycle pulse on solver timeout
//   frames_done           completed output frames, wraps modulo 256
module rs_decode_sequencer #(
  parameter int N          = 15,
  parameter int K          = 11,
  parameter int BM_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       synd_clear,
  output logic       synd_en,
  output logic [3:0] sym_index,
  input  logic       synd_zero,
  output logic       bm_start,
  input  logic       bm_done,
  output logic       corr_en,
  output logic       bypass,
  output logic [3:0] corr_index,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_err,
  output logic [7:0] frames_done
);

  localparam logic [3:0] LAST  = 4'(N - 1);
  localparam int         TW    = $clog2(BM_TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(BM_TIMEOUT - 1);

  // K only describes the code; sequencing is independent of it. Empty guard
  // block keeps the parameter referenced.
  if (K >= N) begin : g_k_not_below_n
  end

  typedef enum logic [1:0] {
    RECV    = 2'd0,
    SYND    = 2'd1,
    BM_WAIT = 2'd2,
    CORRECT = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic          out_xfer;
  logic          timeout;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    corr_en   = 1'b0;
    bm_start  = 1'b0;
    frame_err = 1'b0;
    timeout   = 1'b0;
    case (state)
      RECV: begin
        in_ready = 1'b1;
        if (in_valid && sym_index == LAST) state_nxt = SYND;
      end
      SYND: begin
        if (synd_zero) begin
          state_nxt = CORRECT;
        end else begin
          bm_start  = 1'b1;
          state_nxt = BM_WAIT;
        end
      end
      BM_WAIT: begin
        // bm_done in the final cycle wins over the timeout
        if (bm_done) begin
          state_nxt = CORRECT;
        end else if (tcnt == TLAST) begin
          timeout   = 1'b1;
          frame_err = 1'b1;
          state_nxt = CORRECT;
        end
      end
      CORRECT: begin
        corr_en = 1'b1;
        if (out_ready && corr_index == LAST) state_nxt = RECV;
      end
      default: state_nxt = RECV;
    endcase
  end

  assign synd_en    = in_valid & in_ready;
  assign synd_clear = synd_en & (sym_index == 4'd0);
  assign out_valid  = corr_en;
  assign out_last   = out_valid & (corr_index == LAST);
  assign out_xfer   = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= RECV;
      sym_index   <= 4'd0;
      corr_index  <= 4'd0;
      tcnt        <= '0;
      frames_done <= 8'd0;
      bypass      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (synd_en) sym_index <= (sym_index == LAST) ? 4'd0 : sym_index + 4'd1;

      if (state == SYND) begin
        tcnt <= '0;
        if (synd_zero) bypass <= 1'b1;
      end

      if (state == BM_WAIT) begin
        tcnt <= tcnt + 1'b1;
        if (bm_done)      bypass <= 1'b0;
        else if (timeout) bypass <= 1'b1;
      end

      if (out_xfer) begin
        if (corr_index == LAST) begin
          corr_index  <= 4'd0;
          frames_done <= frames_done + 8'd1;
          bypass      <= 1'b0;
        end else begin
          corr_index <= corr_index + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// Purpose : directed + randomized frame-level bench for rs_decode_sequencer.
// Latency : one frame model per run_frame call, outputs checked mid-cycle.
// Backpres: out_ready driven always-high, random, or in a 1,0,0 pattern.
module tb_rs_decode_sequencer;

  localparam int N  = 15;
  localparam int BT = 16;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       in_valid, in_ready, synd_clear, synd_en;
  logic [3:0] sym_index;
  logic       synd_zero, bm_start, bm_done;
  logic       corr_en, bypass;
  logic [3:0] corr_index;
  logic       out_valid, out_ready, out_last, frame_err;
  logic [7:0] frames_done;

  int checks = 0;
  int errors = 0;
  int exp_fd = 0;

  rs_decode_sequencer #(.N(N), .K(11), .BM_TIMEOUT(BT)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .synd_clear(synd_clear), .synd_en(synd_en),
    .sym_index(sym_index), .synd_zero(synd_zero), .bm_start(bm_start), .bm_done(bm_done),
    .corr_en(corr_en), .bypass(bypass), .corr_index(corr_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_err(frame_err), .frames_done(frames_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge and checked 1 unit later.
  task automatic edge_step();
    @(posedge CLK);
    #1;
  endtask

  // One whole frame. bmd: BM_WAIT cycle (1..BT) in which bm_done rises, 0 = never.
  // rmode: 0 ready always, 1 random, 2 pattern 1,0,0. abort_at: output index at which
  // RESET is pulsed (-1 none). gapmax: 0 = back-to-back input, larger = random idles.
  task automatic run_frame(input bit sz, input int bmd, input int rmode,
                           input int abort_at, input int gapmax);
    int  k, t, j;
    bit  timed_out, exp_byp;
    k = 0;
    t = 0;
    while (k < N) begin
      in_valid = ($urandom_range(0, gapmax) == 0);
      #1;
      chk1("recv_in_ready", in_ready, 1'b1);
      chkn("recv_sym_index", 32'(sym_index), k);
      chk1("recv_synd_en", synd_en, in_valid);
      chk1("recv_synd_clear", synd_clear, in_valid && k == 0);
      chk1("recv_out_valid", out_valid, 1'b0);
      chk1("recv_bm_start", bm_start, 1'b0);
      edge_step();
      if (in_valid) k++;
      t++;
      if (t > 400) begin
        chk1("recv_budget", 1'b0, 1'b1);
        return;
      end
    end

    in_valid  = 1'b1;
    synd_zero = sz;
    #1;
    chk1("synd_in_ready", in_ready, 1'b0);
    chk1("synd_synd_en", synd_en, 1'b0);
    chk1("synd_bm_start", bm_start, !sz);
    chk1("synd_out_valid", out_valid, 1'b0);
    chk1("synd_frame_err", frame_err, 1'b0);
    edge_step();
    synd_zero = 1'($urandom);

    timed_out = 1'b0;
    if (!sz) begin
      for (int c = 1; c <= BT; c++) begin
        bm_done  = (c == bmd);
        in_valid = 1'($urandom);
        #1;
        chk1("bm_frame_err", frame_err, (c == BT) && (c != bmd));
        chk1("bm_bm_start", bm_start, 1'b0);
        chk1("bm_out_valid", out_valid, 1'b0);
        chk1("bm_synd_en", synd_en, 1'b0);
        edge_step();
        if (c == bmd) break;
        if (c == BT) timed_out = 1'b1;
      end
    end
    bm_done = 1'($urandom);
    exp_byp = sz || timed_out;

    j = 0;
    t = 0;
    while (j < N) begin
      if (rmode == 0)      out_ready = 1'b1;
      else if (rmode == 1) out_ready = 1'($urandom);
      else                 out_ready = (t % 3 == 0);
      in_valid = 1'($urandom);
      #1;
      chk1("out_valid", out_valid, 1'b1);
      chk1("out_corr_en", corr_en, 1'b1);
      chk1("out_in_ready", in_ready, 1'b0);
      chk1("out_synd_en", synd_en, 1'b0);
      chk1("out_bypass", bypass, exp_byp);
      chk1("out_last", out_last, j == N - 1);
      chk1("out_frame_err", frame_err, 1'b0);
      chkn("out_corr_index", 32'(corr_index), j);
      chkn("out_frames_done", 32'(frames_done), exp_fd);
      if (j == abort_at) begin
        RESET = 1'b1;
        edge_step();
        RESET     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        exp_fd = 0;
        chk1("rst_in_ready", in_ready, 1'b1);
        chkn("rst_sym_index", 32'(sym_index), 0);
        chkn("rst_corr_index", 32'(corr_index), 0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_frame_err", frame_err, 1'b0);
        chk1("rst_bypass", bypass, 1'b0);
        chkn("rst_frames_done", 32'(frames_done), exp_fd);
        return;
      end
      edge_step();
      if (out_ready) j++;
      t++;
      if (t > 400) begin
        chk1("out_budget", 1'b0, 1'b1);
        return;
      end
    end
    exp_fd = (exp_fd + 1) % 256;
    in_valid = 1'b0;
    #1;
    chk1("end_in_ready", in_ready, 1'b1);
    chk1("end_out_valid", out_valid, 1'b0);
    chk1("end_bypass", bypass, 1'b0);
    chkn("end_sym_index", 32'(sym_index), 0);
    chkn("end_corr_index", 32'(corr_index), 0);
    chkn("end_frames_done", 32'(frames_done), exp_fd);
  endtask

  initial begin
    RESET     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    synd_zero = 1'b0;
    bm_done   = 1'b0;
    edge_step();
    #1;
    chk1("reset_in_ready", in_ready, 1'b1);
    chkn("reset_sym_index", 32'(sym_index), 0);
    chkn("reset_corr_index", 32'(corr_index), 0);
    chkn("reset_frames_done", 32'(frames_done), 0);
    chk1("reset_bypass", bypass, 1'b0);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_bm_start", bm_start, 1'b0);
    chk1("reset_frame_err", frame_err, 1'b0);
    RESET = 1'b0;

    // clean, errored (bm_done 5 cycles in), timeout, timeout tie, backpressure
    run_frame(1'b1, 0,  0, -1, 0);
    run_frame(1'b0, 5,  0, -1, 0);
    run_frame(1'b0, 0,  0, -1, 0);
    run_frame(1'b0, BT, 0, -1, 0);
    run_frame(1'b1, 0,  2, -1, 0);
    run_frame(1'b0, 2,  2, -1, 0);

    // randomized frames
    for (int f = 0; f < 24; f++)
      run_frame(1'($urandom), int'($urandom_range(0, BT)), int'($urandom_range(0, 2)),
                -1, int'($urandom_range(0, 3)));

    // reset during CORRECT at corr_index 7, then a frame from scratch
    run_frame(1'b0, 3, 0, 7, 0);
    run_frame(1'b1, 0, 1, -1, 2);

    // frames_done wrap: reset, then 256 frames
    RESET = 1'b1;
    edge_step();
    RESET = 1'b0;
    exp_fd = 0;
    for (int f = 0; f < 256; f++) run_frame(1'b1, 0, 0, -1, 0);
    chkn("fd_wrap", 32'(frames_done), exp_fd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
